tg_seq_ctrl: RTL
================

Name: tg_seq_ctrl

Overview:
Power-up sequencer and configuration scheduler for the timing generator.
- Gates the generator's active-low reset through a wake/settle sequence.
- Holds shadow copies of the three B-config words and applies host updates only at generator period boundaries, so no period runs with a torn configuration.
- Sits between the synchronized power-up domain and the timing generator instance.

Parameters:
CFG_W, 4, width of each config word
CNT_W, 8, sequence counter width
WAKE_CYC, 16, cycles spent in WAKE (1..2^CNT_W)
SETTLE_CYC, 4, cycles in SETTLE with generator reset held (1..2^CNT_W)
CFG1_DEF, 5, reset value of shadow/applied word 1
CFG2_DEF, 7, reset value of shadow/applied word 2
CFG3_DEF, 9, reset value of shadow/applied word 3
TMO_CYC, 64, frame-end timeout (only with optional feature)

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
pu_req  in  1  power-up request level; already synchronized to clk
cfg_req  in  1  host config update request, level; held until cfg_ack
cfg_b1  in  CFG_W  requested word 1
cfg_b2  in  CFG_W  requested word 2
cfg_b3  in  CFG_W  requested word 3
cfg_ack  out  1  one-cycle pulse when the update is applied to tg_b*
tg_frame_end  in  1  one-cycle pulse from the generator at period end
tg_b1  out  CFG_W  applied word 1 to the generator
tg_b2  out  CFG_W  applied word 2 to the generator
tg_b3  out  CFG_W  applied word 3 to the generator
tg_rstb  out  1  active-low reset to the generator
tg_run  out  1  high only in RUN
seq_state  out  3  current state encoding
err_tmo  out  1  sticky frame-end timeout flag (optional feature)

Behaviour:
- Reset values:
  - state OFF (encoding 0); tg_rstb=0, tg_run=0, cfg_ack=0, err_tmo=0
  - shadow and tg_b1/2/3 = CFG1_DEF/CFG2_DEF/CFG3_DEF; pend=0; counter=0
- State encodings: OFF=0, WAKE=1, LOAD=2, SETTLE=3, RUN=4.
- Transitions, all registered:
  - OFF: pu_req=1 -> WAKE, counter<=WAKE_CYC-1.
  - WAKE: decrement each cycle; at counter==0 -> LOAD. WAKE therefore lasts exactly WAKE_CYC cycles.
  - LOAD: one cycle; tg_b* <= shadow. If pend=1, assert cfg_ack and clear pend. Then -> SETTLE, counter<=SETTLE_CYC-1.
  - SETTLE: tg_rstb stays 0; decrement; at counter==0 -> RUN.
  - RUN: tg_rstb=1 and tg_run=1, both registered and asserted from the first RUN cycle.
- pu_req=0 in any non-OFF state -> OFF next cycle: tg_rstb=0, tg_run=0 immediately, counter cleared. Shadow, pend and tg_b* are retained.
- Capture: when cfg_req=1 and pend=0, shadow <= cfg_b*, pend <= 1. This is allowed in every state.
- cfg_req while pend=1 is ignored. Host holds req and drops it after ack; a re-capture occurs if req is still high in the cycle after ack.
- Apply in RUN: when pend=1 and tg_frame_end=1 -> tg_b* <= shadow, cfg_ack=1, pend<=0.
- Capture and tg_frame_end in the same cycle: the capture happens, but application waits for the next tg_frame_end. There is no same-cycle bypass.
- tg_frame_end is ignored outside RUN. A pend set in OFF/WAKE/SETTLE is applied at the next LOAD or RUN frame end.
- pu_req drop with pend=1: pend is kept; the update is applied in the next LOAD.
- tg_b* change only in LOAD or on an apply event.
- cfg_ack is never asserted in two consecutive cycles.

Optional Feature:
Macro TG_SEQ_TMO_EN.
- Defined:
  - A timeout counter runs in RUN while pend=1 and is cleared on apply or on leaving RUN.
  - If it reaches TMO_CYC with no tg_frame_end: force the apply (tg_b*, cfg_ack), set err_tmo sticky until rst.
- Undefined: no timeout counter; err_tmo tied 0; a pending update waits indefinitely.

Decomposition:
Shared package tg_seq_pkg holds:
- the state enum (OFF/WAKE/LOAD/SETTLE/RUN with the fixed encodings)
- CFG_W default
- the three default config constants

One sub-module, tg_seq_shadow: shadow registers, pend flag, capture/apply and cfg_ack generation. The FSM and counters stay in the top.

Test Plan:
- Power-up: rst 1->0, pu_req=1 at cycle 0 -> WAKE cycles 1-16, LOAD 17, SETTLE 18-21, tg_rstb=1/tg_run=1 from cycle 22; tg_b*=5/7/9 throughout.
- Update in RUN: cfg_req with 3/4/6, tg_frame_end 10 cycles later -> tg_b*=3/4/6 and cfg_ack pulse in the same cycle as the frame end; values stay 5/7/9 before it.
- Simultaneous: cfg_req captured in the same cycle as tg_frame_end -> no apply; apply on the following tg_frame_end only.
- Pre-run update: cfg_req 1/2/3 during WAKE -> cfg_ack in LOAD cycle 17, tg_b*=1/2/3 at SETTLE entry.
- Mid-sequence drop: pu_req falls in SETTLE -> OFF next cycle, tg_rstb stays 0; re-raise -> full 16+1+4 sequence repeats.
- With TG_SEQ_TMO_EN and TMO_CYC=64: pend in RUN, no frame end for 64 cycles -> forced apply, cfg_ack=1, err_tmo=1 until rst.

Source files
------------

// File: rtl/tg_seq_pkg.sv
// tg_seq_pkg: shared types and constants for the timing-generator power-up
// sequencer and configuration scheduler.
package tg_seq_pkg;

  // Default width of each B-config word.
  localparam int TG_CFG_W = 4;

  // Reset values of the shadow and applied B-config words.
  localparam int TG_CFG1_DEF = 5;
  localparam int TG_CFG2_DEF = 7;
  localparam int TG_CFG3_DEF = 9;

  // Sequencer states. The encodings are visible on seq_state and must not change.
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_WAKE   = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RUN    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/tg_seq_ctrl_if.sv
// tg_seq_ctrl_if: host/power/generator-facing signal bundle of tg_seq_ctrl.
// The master modport is the environment (power domain, host, generator);
// the slave modport is the sequencer itself.
interface tg_seq_ctrl_if
  import tg_seq_pkg::*;
#(
  parameter int CFG_W = TG_CFG_W
) ();

  logic             pu_req;
  logic             cfg_req;
  logic [CFG_W-1:0] cfg_b1;
  logic [CFG_W-1:0] cfg_b2;
  logic [CFG_W-1:0] cfg_b3;
  logic             cfg_ack;
  logic             tg_frame_end;
  logic [CFG_W-1:0] tg_b1;
  logic [CFG_W-1:0] tg_b2;
  logic [CFG_W-1:0] tg_b3;
  logic             tg_rstb;
  logic             tg_run;
  logic [2:0]       seq_state;
  logic             err_tmo;

  modport master (
    output pu_req, cfg_req, cfg_b1, cfg_b2, cfg_b3, tg_frame_end,
    input  cfg_ack, tg_b1, tg_b2, tg_b3, tg_rstb, tg_run, seq_state, err_tmo
  );

  modport slave (
    input  pu_req, cfg_req, cfg_b1, cfg_b2, cfg_b3, tg_frame_end,
    output cfg_ack, tg_b1, tg_b2, tg_b3, tg_rstb, tg_run, seq_state, err_tmo
  );

endinterface

// File: rtl/tg_seq_shadow.sv
// tg_seq_shadow: shadow copies of the three B-config words, the pending flag,
// capture of host requests and application of the shadow to the generator.
// The applied words only move on a LOAD cycle or on an apply event, so the
// generator never sees a partially updated configuration within a period.
module tg_seq_shadow
  import tg_seq_pkg::*;
#(
  parameter int CFG_W    = TG_CFG_W,
  parameter int CFG1_DEF = TG_CFG1_DEF,
  parameter int CFG2_DEF = TG_CFG2_DEF,
  parameter int CFG3_DEF = TG_CFG3_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_req_i,
  input  logic [CFG_W-1:0] cfg_b1_i,
  input  logic [CFG_W-1:0] cfg_b2_i,
  input  logic [CFG_W-1:0] cfg_b3_i,
  input  logic             load_i,    // sequencer is in LOAD this cycle
  input  logic             fe_i,      // generator frame end while in RUN
  input  logic             force_i,   // timeout-forced apply
  output logic             ack_o,
  output logic             pend_o,
  output logic [CFG_W-1:0] tg_b1_o,
  output logic [CFG_W-1:0] tg_b2_o,
  output logic [CFG_W-1:0] tg_b3_o
);

  localparam logic [CFG_W-1:0] DEF1 = CFG_W'(CFG1_DEF);
  localparam logic [CFG_W-1:0] DEF2 = CFG_W'(CFG2_DEF);
  localparam logic [CFG_W-1:0] DEF3 = CFG_W'(CFG3_DEF);

  logic [CFG_W-1:0] sh1_q, sh1_d;
  logic [CFG_W-1:0] sh2_q, sh2_d;
  logic [CFG_W-1:0] sh3_q, sh3_d;
  logic [CFG_W-1:0] b1_q, b1_d;
  logic [CFG_W-1:0] b2_q, b2_d;
  logic [CFG_W-1:0] b3_q, b3_d;
  logic             pend_q, pend_d;
  logic             ack_s;
  logic             upd_s;

  // Apply decision, pending-flag update and shadow capture.
  always_comb begin
    sh1_d  = sh1_q;
    sh2_d  = sh2_q;
    sh3_d  = sh3_q;
    b1_d   = b1_q;
    b2_d   = b2_q;
    b3_d   = b3_q;
    pend_d = pend_q;

    // Ack only when a pending update is actually consumed; LOAD always
    // refreshes the applied words, pending or not.
    ack_s = pend_q & (load_i | fe_i | force_i);
    upd_s = load_i | ack_s;

    if (upd_s) begin
      b1_d = sh1_q;
      b2_d = sh2_q;
      b3_d = sh3_q;
    end else begin
      b1_d = b1_q;
      b2_d = b2_q;
      b3_d = b3_q;
    end

    // Capture and apply are exclusive (pend 0 vs 1), which is why a request
    // captured on a frame-end cycle waits for the next frame end.
    if (ack_s) begin
      pend_d = 1'b0;
    end else if (cfg_req_i && !pend_q) begin
      pend_d = 1'b1;
      sh1_d  = cfg_b1_i;
      sh2_d  = cfg_b2_i;
      sh3_d  = cfg_b3_i;
    end else begin
      pend_d = pend_q;
    end
  end

  // Shadow, applied-word and pending-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh1_q  <= DEF1;
      sh2_q  <= DEF2;
      sh3_q  <= DEF3;
      b1_q   <= DEF1;
      b2_q   <= DEF2;
      b3_q   <= DEF3;
      pend_q <= 1'b0;
    end else begin
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      sh3_q  <= sh3_d;
      b1_q   <= b1_d;
      b2_q   <= b2_d;
      b3_q   <= b3_d;
      pend_q <= pend_d;
    end
  end

  assign ack_o   = ack_s;
  assign pend_o  = pend_q;
  assign tg_b1_o = b1_q;
  assign tg_b2_o = b2_q;
  assign tg_b3_o = b3_q;

endmodule

// File: rtl/tg_seq_ctrl.sv
// tg_seq_ctrl: power-up sequencer (OFF/WAKE/LOAD/SETTLE/RUN) gating the timing
// generator reset, plus frame-boundary scheduling of B-config updates.
// Optional feature: define TG_SEQ_TMO_EN to force a pending update after
// TMO_CYC RUN cycles without a frame end and raise the sticky err_tmo flag.
module tg_seq_ctrl
  import tg_seq_pkg::*;
#(
  parameter int CFG_W      = TG_CFG_W,
  parameter int CNT_W      = 8,
  parameter int WAKE_CYC   = 16,
  parameter int SETTLE_CYC = 4,
  parameter int CFG1_DEF   = TG_CFG1_DEF,
  parameter int CFG2_DEF   = TG_CFG2_DEF,
  parameter int CFG3_DEF   = TG_CFG3_DEF,
  parameter int TMO_CYC    = 64
) (
  input  logic          clk,
  input  logic          rst,
  tg_seq_ctrl_if.slave  bus
);

  // Counters load N-1 so that WAKE/SETTLE last exactly N cycles.
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LD   = CNT_W'(WAKE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  seq_state_e       state_q, state_d, fsm_nxt_s;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt_s;
  logic             rstb_q, rstb_d;
  logic             run_q, run_d;
  logic             load_s;
  logic             fe_s;
  logic             force_s;
  logic             pend_s;
  logic             ack_s;
  logic             err_tmo_s;
  logic [CFG_W-1:0] b1_s, b2_s, b3_s;

  // Sequencer next state and counter; dropping pu_req overrides everything.
  always_comb begin
    fsm_nxt_s = state_q;
    cnt_nxt_s = cnt_q;
    state_d   = state_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_OFF: begin
        if (bus.pu_req) begin
          fsm_nxt_s = ST_WAKE;
          cnt_nxt_s = WAKE_LD;
        end else begin
          fsm_nxt_s = ST_OFF;
          cnt_nxt_s = CNT_ZERO;
        end
      end
      ST_WAKE: begin
        if (cnt_q == CNT_ZERO) begin
          fsm_nxt_s = ST_LOAD;
          cnt_nxt_s = CNT_ZERO;
        end else begin
          fsm_nxt_s = ST_WAKE;
          cnt_nxt_s = cnt_q - CNT_ONE;
        end
      end
      ST_LOAD: begin
        fsm_nxt_s = ST_SETTLE;
        cnt_nxt_s = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_ZERO) begin
          fsm_nxt_s = ST_RUN;
          cnt_nxt_s = CNT_ZERO;
        end else begin
          fsm_nxt_s = ST_SETTLE;
          cnt_nxt_s = cnt_q - CNT_ONE;
        end
      end
      ST_RUN: begin
        fsm_nxt_s = ST_RUN;
        cnt_nxt_s = CNT_ZERO;
      end
      default: begin
        fsm_nxt_s = ST_OFF;
        cnt_nxt_s = CNT_ZERO;
      end
    endcase

    if ((state_q != ST_OFF) && !bus.pu_req) begin
      state_d = ST_OFF;
      cnt_d   = CNT_ZERO;
    end else begin
      state_d = fsm_nxt_s;
      cnt_d   = cnt_nxt_s;
    end

    // Generator reset release and run flag follow the registered state,
    // so both are high from the very first RUN cycle.
    rstb_d = (state_d == ST_RUN);
    run_d  = (state_d == ST_RUN);
  end

  // Sequencer state, counter and generator control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      cnt_q   <= CNT_ZERO;
      rstb_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstb_q  <= rstb_d;
      run_q   <= run_d;
    end
  end

  // Frame ends only count while the generator is running.
  assign load_s = (state_q == ST_LOAD);
  assign fe_s   = (state_q == ST_RUN) & bus.tg_frame_end;

`ifdef TG_SEQ_TMO_EN
  localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_ZERO = TMO_W'(0);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Timeout: count RUN cycles waiting with an update pending; force on the last.
  always_comb begin
    tmo_d   = TMO_ZERO;
    force_s = 1'b0;
    err_d   = err_q;
    if ((state_q == ST_RUN) && pend_s && !bus.tg_frame_end) begin
      if (tmo_q == TMO_LAST) begin
        force_s = 1'b1;
        tmo_d   = TMO_ZERO;
        err_d   = 1'b1;
      end else begin
        force_s = 1'b0;
        tmo_d   = tmo_q + TMO_ONE;
        err_d   = err_q;
      end
    end else begin
      force_s = 1'b0;
      tmo_d   = TMO_ZERO;
      err_d   = err_q;
    end
  end

  // Timeout counter and sticky error flag (cleared only by rst).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= TMO_ZERO;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_tmo_s = err_q;
`else
  assign force_s   = 1'b0;
  assign err_tmo_s = 1'b0;

  // pend and TMO_CYC only feed the timeout logic, which is absent here.
  logic unused_tmo_s;
  assign unused_tmo_s = &{1'b0, pend_s, (TMO_CYC > 0)};
`endif

  tg_seq_shadow #(
    .CFG_W    (CFG_W),
    .CFG1_DEF (CFG1_DEF),
    .CFG2_DEF (CFG2_DEF),
    .CFG3_DEF (CFG3_DEF)
  ) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .cfg_req_i (bus.cfg_req),
    .cfg_b1_i  (bus.cfg_b1),
    .cfg_b2_i  (bus.cfg_b2),
    .cfg_b3_i  (bus.cfg_b3),
    .load_i    (load_s),
    .fe_i      (fe_s),
    .force_i   (force_s),
    .ack_o     (ack_s),
    .pend_o    (pend_s),
    .tg_b1_o   (b1_s),
    .tg_b2_o   (b2_s),
    .tg_b3_o   (b3_s)
  );

  assign bus.cfg_ack   = ack_s;
  assign bus.tg_b1     = b1_s;
  assign bus.tg_b2     = b2_s;
  assign bus.tg_b3     = b3_s;
  assign bus.tg_rstb   = rstb_q;
  assign bus.tg_run    = run_q;
  assign bus.seq_state = state_q;
  assign bus.err_tmo   = err_tmo_s;

endmodule
